// File: rtl/mem_arbiter_rr_pkg.sv
// Shared definitions for the round-robin memory arbiter: FSM encodings and default RAM widths.
package mem_arbiter_rr_pkg;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_HOLD   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_rr_pick.sv
// rr_pick: combinational round-robin selector. Returns the first requester at or after rr_ptr,
// wrapping modulo N_PORTS explicitly so non-power-of-two port counts work.
module mem_arbiter_rr_rr_pick #(
    parameter int N_PORTS = 2,
    localparam int PTR_W  = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [PTR_W-1:0]   winner,
    output logic               valid
);

    logic [PTR_W-1:0]   cand [N_PORTS];
    logic [N_PORTS-1:0] rot_req;

    // cand[gi] is the port examined at search distance gi from rr_ptr
    genvar gi;
    generate
        for (gi = 0; gi < N_PORTS; gi++) begin : g_rot
            assign cand[gi]    = (int'(rr_ptr) + gi >= N_PORTS) ? PTR_W'(int'(rr_ptr) + gi - N_PORTS)
                                                                 : PTR_W'(int'(rr_ptr) + gi);
            assign rot_req[gi] = req[cand[gi]];
        end
    endgenerate

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                winner = cand[k];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-port round-robin arbiter in front of one single-port synchronous RAM (1-cycle read latency).
// Optional per-port stall counters are enabled with `define MEMARB_STALL_CNT_EN.
module mem_arbiter_rr
    import mem_arbiter_rr_pkg::*;
#(
    parameter int N_PORTS = 2,
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DATA_W  = MEM_DATA_W
) (
    input  logic                    CLK,
    input  logic                    rst,
    input  logic [N_PORTS-1:0]      rden,
    input  logic [N_PORTS-1:0]      wren,
    input  logic [N_PORTS*ADDR_W-1:0] Address,
    input  logic [N_PORTS*DATA_W-1:0] Din,
    input  logic [DATA_W-1:0]       RAMq,
    output logic [N_PORTS-1:0]      acq,
    output logic [N_PORTS*DATA_W-1:0] Dq,
    output logic [ADDR_W-1:0]       RAMAddress,
    output logic [DATA_W-1:0]       RAMDin,
    output logic                    RAMwren
`ifdef MEMARB_STALL_CNT_EN
    ,
    output logic [N_PORTS*32-1:0]   stall_cnt
`endif
);

    localparam int PTR_W = $clog2(N_PORTS);

    arb_state_t         state_reg, state_next;
    logic [PTR_W-1:0]   owner_reg, owner_next;
    logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [N_PORTS-1:0] acq_reg, acq_next;
    logic [ADDR_W-1:0]  ram_addr_reg, ram_addr_next;
    logic [DATA_W-1:0]  ram_din_reg, ram_din_next;
    logic               ram_wren_reg, ram_wren_next;
    logic [DATA_W-1:0]  dq_reg [N_PORTS];
    logic               dq_we;

    logic [N_PORTS-1:0] req;
    logic [ADDR_W-1:0]  addr_arr [N_PORTS];
    logic [DATA_W-1:0]  din_arr  [N_PORTS];
    logic [PTR_W-1:0]   winner;
    logic               win_valid;

    genvar gi;
    generate
        for (gi = 0; gi < N_PORTS; gi++) begin : g_port
            assign req[gi]                    = rden[gi] | wren[gi];
            assign addr_arr[gi]               = Address[gi*ADDR_W +: ADDR_W];
            assign din_arr[gi]                = Din[gi*DATA_W +: DATA_W];
            assign Dq[gi*DATA_W +: DATA_W]    = dq_reg[gi];
        end
    endgenerate

    mem_arbiter_rr_rr_pick #(.N_PORTS(N_PORTS)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_reg),
        .winner (winner),
        .valid  (win_valid)
    );

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        rr_ptr_next   = rr_ptr_reg;
        acq_next      = acq_reg;
        ram_addr_next = ram_addr_reg;
        ram_din_next  = ram_din_reg;
        ram_wren_next = 1'b0;
        dq_we         = 1'b0;
        case (state_reg)
            ARB_IDLE: begin
                acq_next = '0;
                if (win_valid) begin
                    owner_next    = winner;
                    ram_addr_next = addr_arr[winner];
                    ram_din_next  = din_arr[winner];
                    ram_wren_next = wren[winner];
                    state_next    = ARB_ACCESS;
                end
            end
            ARB_ACCESS: state_next = ARB_HOLD;
            ARB_HOLD: begin
                // acq still low means this is the first HOLD cycle: RAMq is valid now
                if (acq_reg == '0) begin
                    dq_we    = 1'b1;
                    acq_next = N_PORTS'(1) << owner_reg;
                end else if (!req[owner_reg]) begin
                    acq_next    = '0;
                    rr_ptr_next = (owner_reg == PTR_W'(N_PORTS - 1)) ? '0 : owner_reg + 1'b1;
                    state_next  = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_reg    <= ARB_IDLE;
            owner_reg    <= '0;
            rr_ptr_reg   <= '0;
            acq_reg      <= '0;
            ram_addr_reg <= '0;
            ram_din_reg  <= '0;
            ram_wren_reg <= 1'b0;
            for (int i = 0; i < N_PORTS; i++) begin
                dq_reg[i] <= '0;
            end
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            rr_ptr_reg   <= rr_ptr_next;
            acq_reg      <= acq_next;
            ram_addr_reg <= ram_addr_next;
            ram_din_reg  <= ram_din_next;
            ram_wren_reg <= ram_wren_next;
            if (dq_we) begin
                dq_reg[owner_reg] <= RAMq;
            end
        end
    end

    assign acq        = acq_reg;
    assign RAMAddress = ram_addr_reg;
    assign RAMDin     = ram_din_reg;
    assign RAMwren    = ram_wren_reg;

`ifdef MEMARB_STALL_CNT_EN
    // Cycles spent requesting without a grant, saturating
    generate
        for (gi = 0; gi < N_PORTS; gi++) begin : g_stall
            logic [31:0] stall_reg;
            always_ff @(posedge CLK or posedge rst) begin
                if (rst) begin
                    stall_reg <= '0;
                end else if (req[gi] && !acq_reg[gi] && stall_reg != 32'hFFFF_FFFF) begin
                    stall_reg <= stall_reg + 32'd1;
                end
            end
            assign stall_cnt[gi*32 +: 32] = stall_reg;
        end
    endgenerate
`endif

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Parametrised N-port arbiter between multiple cores and one single-port synchronous RAM (IRAM or DRAM); generalises the existing two-core memory controllers.
- Round-robin grant with an acq handshake; RAM read latency of 1 cycle is hidden behind the handshake.
- Instantiated once per shared RAM in the multicore top level. Core i connects to slice i of each flattened bus.

Parameters:
N_PORTS, 2, number of requesting cores (>=2)
ADDR_W, 8, RAM address width
DATA_W, 8, RAM data width

Ports:
CLK  input  1  system clock (divided clock); all state updates on rising edge
rst  input  1  asynchronous, active-high reset
rden  input  N_PORTS  per-port read request; bit i = core i
wren  input  N_PORTS  per-port write request
Address  input  N_PORTS*ADDR_W  per-port address; port i at [i*ADDR_W +: ADDR_W]
Din  input  N_PORTS*DATA_W  per-port write data
RAMq  input  DATA_W  RAM read data, valid 1 cycle after the address edge
acq  output  N_PORTS  per-port grant/complete; one-hot or zero
Dq  output  N_PORTS*DATA_W  per-port registered read data
RAMAddress  output  ADDR_W  registered RAM address
RAMDin  output  DATA_W  registered RAM write data
RAMwren  output  1  registered RAM write enable

Behaviour:
- Reset (async, any state): state=IDLE, acq=0, every Dq slice=0, RAMAddress=0, RAMDin=0, RAMwren=0, rr_ptr=0.
- req[i] = rden[i] | wren[i].
- Winner = first i with req[i]=1, searching rr_ptr, rr_ptr+1, … mod N_PORTS.
- FSM states: IDLE, ACCESS, HOLD.
- IDLE:
  - If any req, on the edge: latch owner=winner, RAMAddress=Address[owner], RAMDin=Din[owner], RAMwren=wren[owner]; go to ACCESS.
  - Otherwise stay; RAMwren=0.
- ACCESS (exactly 1 cycle): RAM samples address and write on the edge ending this cycle. On that edge: RAMwren<=0, go to HOLD.
- HOLD:
  - First cycle: Dq[owner]<=RAMq (captured on the edge entering HOLD+1) and acq[owner]=1.
  - acq[owner] stays 1 while req[owner]=1.
  - When req[owner]=0 is sampled: acq<=0, rr_ptr<=(owner+1) mod N_PORTS, go to IDLE.
  - acq is high for at least 1 cycle.
- Latency: req sampled at edge E0; RAM access at E1; acq and Dq valid after E2, i.e. 2 cycles.
- Minimum back-to-back turnaround is 4 cycles per transaction, including the release cycle.
- Simultaneous rden & wren on the same port: treated as a write. Dq still captures RAMq, with the RAM's read-during-write value.
- RAMwren is asserted for exactly one cycle per write transaction. It is never asserted while in IDLE or HOLD.
- Requester drops req during ACCESS: the transaction completes anyway (a write is committed). acq pulses for exactly 1 cycle, then the FSM releases.
- Non-owner Dq slices hold their values. Non-owner acq bits stay 0.
- Requests arriving during ACCESS/HOLD wait; they are considered in the next IDLE cycle.
- Fairness: a continuously requesting port waits at most N_PORTS-1 transactions.
- Address/Din from a port are sampled only in IDLE. Changes later in the transaction are ignored.
- N_PORTS=1 is not supported. rr_ptr width is clog2(N_PORTS), and wrap is explicit (not power-of-two reliant).

Optional Feature:
- Macro: MEMARB_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [N_PORTS*32-1:0]. Slice i increments each cycle req[i]=1 and acq[i]=0.
  - Counters saturate at 32'hFFFFFFFF and reset to 0 on rst.
  - Intended for comparison against clkcount in the multicore top level.
- Undefined: port absent, no counters, behaviour otherwise identical.

Decomposition:
- Shared package/define file (alongside define.v):
  - FSM state encodings ARB_IDLE=2'd0, ARB_ACCESS=2'd1, ARB_HOLD=2'd2.
  - Default widths MEM_ADDR_W=8 and MEM_DATA_W=8.
- One sub-module: rr_pick (combinational), with inputs req and rr_ptr and outputs winner index and valid.
- Holding rr_pick separately makes the priority rotation reusable and unit-testable.

Test Plan:
- Reset mid-HOLD with acq[1]=1 → acq=0, RAMwren=0 immediately (async); IDLE next cycle; rr_ptr=0.
- N=2: port0 writes addr 8'h10 data 8'hA5 → RAMwren=1 for exactly 1 cycle with RAMAddress=8'h10 and RAMDin=8'hA5; acq[0]=1 two cycles after the request is sampled. Port1 then reads 8'h10 → Dq[15:8]=8'hA5 when acq[1] rises.
- Both ports request continuously from reset → grants alternate 0,1,0,1. Each acq is held until its req drops.
- N_PORTS=3, ports 0 and 2 request with rr_ptr=1 → port 2 wins first, then port 0.
- Port drops req during ACCESS on a write → memory updated, acq pulses 1 cycle, arbiter back in IDLE 1 cycle later.
- MEMARB_STALL_CNT_EN: port1 waits behind a 5-cycle port0 transaction → stall_cnt[63:32] equals its measured wait cycles. Preload to 32'hFFFFFFFE, stall 3 cycles → value stays 32'hFFFFFFFF.
